// File: rtl/sar_pkg.sv
// Shared types and constants for the SAR conversion host and its sample FIFO.
package sar_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        BUSY,
        PUSH
    } host_state_t;

    localparam int SAR_DATA_W = 5;
    localparam int AVG_N      = 4;

endpackage

// File: rtl/sar_sample_fifo.sv
// First-word-fall-through sample FIFO with occupancy count and overflow detect.
module sar_sample_fifo #(
    parameter int DATA_W     = 5,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          wr_en,
    input  logic [DATA_W-1:0]             wr_data,
    input  logic                          rd_en,
    output logic [DATA_W-1:0]             rd_data,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          ovf
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              do_wr, do_rd;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(FIFO_DEPTH));
    assign count   = count_q;
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

    // A pop in the same cycle frees the slot, so a write while full still lands.
    always_comb begin
        do_rd    = rd_en & ~empty;
        do_wr    = wr_en & (~full | do_rd);
        ovf      = wr_en & full & ~rd_en;
        wr_ptr_d = do_wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_rd ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        case ({do_wr, do_rd})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
        always_comb mem_d[gi] = (do_wr && (wr_ptr_q == AW'(gi))) ? wr_data : mem_q[gi];

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) mem_q[gi] <= '0;
            else        mem_q[gi] <= mem_d[gi];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/sar_conv_host.sv
// SAR ADC conversion initiator: periodic/triggered requests, nEndCnv handshake, sample FIFO.
// Define SAR_HOST_AVG_EN to push the floor-average of every 4 captures instead of each capture.
module sar_conv_host
    import sar_pkg::*;
#(
    parameter int DATA_W     = SAR_DATA_W,
    parameter int PERIOD_W   = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int TMO_CYC    = 63
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [PERIOD_W-1:0]           period,
    input  logic                          trig,
    input  logic                          nEndCnv,
    input  logic [DATA_W-1:0]             adcData,
    output logic                          nStartCnv,
    input  logic                          rd_en,
    output logic [DATA_W-1:0]             rd_data,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          ovf_err,
    output logic                          trig_ovr,
    output logic                          tmo_err,
    input  logic                          clr_err
);
    localparam int TMO_W = $clog2(TMO_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

    host_state_t         state_q, state_d;
    logic [PERIOD_W-1:0] per_cnt_q, per_cnt_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic [DATA_W-1:0]   cap_q, cap_d;
    logic                pending_q, pending_d;
    logic                nstart_q, nstart_d;
    logic                ovf_err_q, ovf_err_d;
    logic                trig_ovr_q, trig_ovr_d;
    logic                tmo_err_q, tmo_err_d;
    logic                tick, req, consume, pend_held, fifo_wr, fifo_ovf, tmo_evt;

`ifdef SAR_HOST_AVG_EN
    localparam int AVG_W = $clog2(AVG_N);
    logic [DATA_W+1:0]   acc_q, acc_d, acc_sum;
    logic [AVG_W-1:0]    avg_cnt_q, avg_cnt_d;
`endif

    always_comb begin
        tick      = 1'b0;
        per_cnt_d = '0;
        if (enable) begin
            if (per_cnt_q == '0) begin
                tick      = 1'b1;
                per_cnt_d = period;
            end else begin
                per_cnt_d = per_cnt_q - 1'b1;
            end
        end
    end

    // A request landing in the cycle IDLE consumes pending is a fresh request, not an overrun.
    always_comb begin
        req        = tick | trig;
        pend_held  = pending_q & ~consume;
        pending_d  = pend_held | req;
        trig_ovr_d = (req & pend_held) | (trig_ovr_q & ~clr_err);
        tmo_err_d  = tmo_evt | (tmo_err_q & ~clr_err);
        ovf_err_d  = fifo_ovf | (ovf_err_q & ~clr_err);
    end

    always_comb begin
        state_d  = state_q;
        nstart_d = nstart_q;
        tmo_d    = tmo_q;
        cap_d    = cap_q;
        consume  = 1'b0;
        fifo_wr  = 1'b0;
        tmo_evt  = 1'b0;
`ifdef SAR_HOST_AVG_EN
        acc_d     = acc_q;
        avg_cnt_d = avg_cnt_q;
        acc_sum   = acc_q + {2'b00, adcData};
`endif
        case (state_q)
            IDLE: begin
                if (pending_q) begin
                    consume  = 1'b1;
                    nstart_d = 1'b0;
                    tmo_d    = '0;
                    state_d  = REQ;
                end
            end
            REQ: begin
                if (nEndCnv) begin
                    nstart_d = 1'b1;
                    tmo_d    = '0;
                    state_d  = BUSY;
                end else if (tmo_q == TMO_LAST) begin
                    nstart_d = 1'b1;
                    tmo_evt  = 1'b1;
                    state_d  = IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            BUSY: begin
                if (!nEndCnv) begin
`ifdef SAR_HOST_AVG_EN
                    if (avg_cnt_q == AVG_W'(AVG_N - 1)) begin
                        cap_d     = acc_sum[AVG_W +: DATA_W];
                        acc_d     = '0;
                        avg_cnt_d = '0;
                        state_d   = PUSH;
                    end else begin
                        acc_d     = acc_sum;
                        avg_cnt_d = avg_cnt_q + 1'b1;
                        state_d   = IDLE;
                    end
`else
                    cap_d   = adcData;
                    state_d = PUSH;
`endif
                end else if (tmo_q == TMO_LAST) begin
                    tmo_evt = 1'b1;
                    state_d = IDLE;
`ifdef SAR_HOST_AVG_EN
                    acc_d     = '0;
                    avg_cnt_d = '0;
`endif
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            PUSH: begin
                fifo_wr = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            per_cnt_q  <= '0;
            tmo_q      <= '0;
            cap_q      <= '0;
            pending_q  <= 1'b0;
            nstart_q   <= 1'b1;
            ovf_err_q  <= 1'b0;
            trig_ovr_q <= 1'b0;
            tmo_err_q  <= 1'b0;
`ifdef SAR_HOST_AVG_EN
            acc_q      <= '0;
            avg_cnt_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            per_cnt_q  <= per_cnt_d;
            tmo_q      <= tmo_d;
            cap_q      <= cap_d;
            pending_q  <= pending_d;
            nstart_q   <= nstart_d;
            ovf_err_q  <= ovf_err_d;
            trig_ovr_q <= trig_ovr_d;
            tmo_err_q  <= tmo_err_d;
`ifdef SAR_HOST_AVG_EN
            acc_q      <= acc_d;
            avg_cnt_q  <= avg_cnt_d;
`endif
        end
    end

    assign nStartCnv = nstart_q;
    assign ovf_err   = ovf_err_q;
    assign trig_ovr  = trig_ovr_q;
    assign tmo_err   = tmo_err_q;

    sar_sample_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (fifo_wr),
        .wr_data (cap_q),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .empty   (empty),
        .full    (full),
        .count   (count),
        .ovf     (fifo_ovf)
    );

endmodule

// File: tb/tb_sar_conv_host.sv
// Self-checking bench for sar_conv_host: converter model, vector table and scoreboard of FIFO samples.
module tb_sar_conv_host;
    import sar_pkg::*;

    localparam int DATA_W     = 5;
    localparam int PERIOD_W   = 16;
    localparam int FIFO_DEPTH = 4;
    localparam int TMO_CYC    = 63;
    localparam int M_NORMAL   = 0;
    localparam int M_NEVER    = 1;
    localparam int M_STUCK    = 2;

    logic                clock, reset, enable, trig, nEndCnv, nStartCnv, rd_en, clr_err;
    logic                empty, full, ovf_err, trig_ovr, tmo_err;
    logic [PERIOD_W-1:0] period;
    logic [DATA_W-1:0]   adcData, rd_data;
    logic [2:0]          count;

    sar_conv_host #(
        .DATA_W     (DATA_W),
        .PERIOD_W   (PERIOD_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .TMO_CYC    (TMO_CYC)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .period    (period),
        .trig      (trig),
        .nEndCnv   (nEndCnv),
        .adcData   (adcData),
        .nStartCnv (nStartCnv),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .ovf_err   (ovf_err),
        .trig_ovr  (trig_ovr),
        .tmo_err   (tmo_err),
        .clr_err   (clr_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              push;
        logic [DATA_W-1:0] exp;
    } vec_t;

    vec_t              vecs [8];
    logic [DATA_W-1:0] sb [$];
    logic [DATA_W-1:0] m_data [$];
    int                total, bad, cyc, low_cyc;
    int                fall_cyc [$];
    logic              prev_ns;
    int                m_mode, m_phase, m_cnt, m_idx, m_conv;
    logic              m_abort;

    // Converter model: nEndCnv rises 2 cycles after a request is seen, falls 18 cycles later.
    initial begin
        nEndCnv = 1'b0;
        adcData = '0;
        m_phase = 0;
        m_cnt   = 0;
        m_idx   = 0;
        m_conv  = 0;
        forever begin
            @(posedge clock);
            #2;
            if (!reset || m_abort) begin
                nEndCnv = 1'b0;
                m_phase = 0;
            end else begin
                case (m_phase)
                    0: if (!nStartCnv && m_mode != M_NEVER) begin
                        m_phase = 1;
                        m_cnt   = 0;
                    end
                    1: begin
                        m_cnt++;
                        if (m_cnt == 2) begin
                            nEndCnv = 1'b1;
                            m_cnt   = 0;
                            m_phase = 2;
                        end
                    end
                    default: if (m_mode != M_STUCK) begin
                        m_cnt++;
                        if (m_cnt == 18) begin
                            adcData = (m_idx < m_data.size()) ? m_data[m_idx] : '0;
                            m_idx++;
                            nEndCnv = 1'b0;
                            m_phase = 0;
                            m_conv++;
                        end
                    end
                endcase
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
        if (!nStartCnv) low_cyc++;
        if (prev_ns && !nStartCnv) fall_cyc.push_back(cyc);
        prev_ns = nStartCnv;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_conv(input int target);
        int n;
        n = 0;
        while (m_conv < target && n < 300) begin
            step();
            n++;
        end
        chk("conversion_done_in_time", m_conv >= target, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int base, nf, n;
        total = 0; bad = 0; cyc = 0; low_cyc = 0; prev_ns = 1'b1;
        reset = 1'b0; enable = 1'b0; trig = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
        period = '0; m_mode = M_NORMAL; m_abort = 1'b0;

        repeat (3) step();
        chk("rst_nStartCnv", nStartCnv, 1);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_count", count, 0);
        chk("rst_flags", {ovf_err, trig_ovr, tmo_err}, 0);
        chk("rst_state_idle", dut.state_q == IDLE, 1);
        reset = 1'b1;
        step();
        chk("idle_no_request", nStartCnv, 1);

        // Single-shot conversions through the vector table.
`ifdef SAR_HOST_AVG_EN
        vecs[0] = '{5'd10, 1'b0, 5'd0};
        vecs[1] = '{5'd11, 1'b0, 5'd0};
        vecs[2] = '{5'd12, 1'b0, 5'd0};
        vecs[3] = '{5'd14, 1'b1, 5'd11};
        vecs[4] = '{5'd31, 1'b0, 5'd0};
        vecs[5] = '{5'd31, 1'b0, 5'd0};
        vecs[6] = '{5'd31, 1'b0, 5'd0};
        vecs[7] = '{5'd31, 1'b1, 5'd31};
`else
        vecs[0] = '{5'd22, 1'b1, 5'd22};
        vecs[1] = '{5'd0,  1'b1, 5'd0};
        vecs[2] = '{5'd31, 1'b1, 5'd31};
        vecs[3] = '{5'd7,  1'b1, 5'd7};
        vecs[4] = '{5'd16, 1'b1, 5'd16};
        vecs[5] = '{5'd1,  1'b1, 5'd1};
        vecs[6] = '{5'd30, 1'b1, 5'd30};
        vecs[7] = '{5'd9,  1'b1, 5'd9};
`endif
        for (int i = 0; i < 8; i++) begin
            base = m_conv;
            m_data.push_back(vecs[i].data);
            if (vecs[i].push) sb.push_back(vecs[i].exp);
            low_cyc = 0;
            trig = 1'b1;
            step();
            trig = 1'b0;
            wait_conv(base + 1);
            chk("count_one_cycle_after_fall", count, 0);
            step();
            chk("count_two_cycles_after_fall", count, vecs[i].push ? 1 : 0);
            chk("req_low_cycles", low_cyc, 3);
            if (vecs[i].push) begin
                chk("single_rd_data", rd_data, sb.pop_front());
                rd_en = 1'b1;
                step();
                rd_en = 1'b0;
                chk("empty_after_pop", empty, 1);
            end
        end

`ifndef SAR_HOST_AVG_EN
        // Periodic requests, FIFO fills, fifth sample overflows.
        base = m_conv;
        nf   = fall_cyc.size();
        for (int v = 1; v <= 5; v++) begin
            m_data.push_back(DATA_W'(v));
            if (v <= 4) sb.push_back(DATA_W'(v));
        end
        period = 16'd39;
        enable = 1'b1;
        n = 0;
        while (fall_cyc.size() < nf + 5 && n < 400) begin
            step();
            n++;
        end
        enable = 1'b0;
        chk("periodic_request_count", fall_cyc.size() - nf, 5);
        for (int k = 1; k < 5; k++)
            chk("periodic_spacing", fall_cyc[nf + k] - fall_cyc[nf + k - 1], 40);
        wait_conv(base + 5);
        repeat (3) step();
        nf = fall_cyc.size();
        repeat (60) step();
        chk("no_request_after_disable", fall_cyc.size() - nf, 0);
        chk("periodic_full", full, 1);
        chk("periodic_count", count, 4);
        chk("periodic_ovf_err", ovf_err, 1);
        for (int k = 0; k < 2; k++) begin
            chk("periodic_pop", rd_data, sb.pop_front());
            rd_en = 1'b1;
            step();
            rd_en = 1'b0;
        end
        chk("count_after_two_pops", count, 2);
`endif

        // Reset while BUSY.
        trig = 1'b1;
        step();
        trig = 1'b0;
        n = 0;
        while (nEndCnv !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        repeat (3) step();
        chk("reached_busy", dut.state_q == BUSY, 1);
        reset = 1'b0;
        #1;
        chk("midrst_nStartCnv", nStartCnv, 1);
        chk("midrst_empty", empty, 1);
        chk("midrst_count", count, 0);
        chk("midrst_rd_data", rd_data, 0);
        chk("midrst_flags", {ovf_err, trig_ovr, tmo_err}, 0);
        sb.delete();
        step();
        step();
        reset = 1'b1;
        step();

        // Timeout in REQ: converter never answers.
        m_mode  = M_NEVER;
        low_cyc = 0;
        trig = 1'b1;
        step();
        trig = 1'b0;
        n = 0;
        while ((nStartCnv == 1'b0 || low_cyc == 0) && n < 200) begin
            step();
            n++;
        end
        chk("req_tmo_low_cycles", low_cyc, TMO_CYC);
        chk("req_tmo_err", tmo_err, 1);
        chk("req_tmo_count", count, 0);
        chk("req_tmo_state_idle", dut.state_q == IDLE, 1);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        chk("req_tmo_cleared", tmo_err, 0);

        // Timeout in BUSY: nEndCnv stuck high.
        m_mode = M_STUCK;
        trig = 1'b1;
        step();
        trig = 1'b0;
        n = 0;
        while (tmo_err !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        chk("busy_tmo_err", tmo_err, 1);
        chk("busy_tmo_state_idle", dut.state_q == IDLE, 1);
        chk("busy_tmo_nStartCnv", nStartCnv, 1);
        repeat (3) step();
        chk("busy_tmo_no_push", count, 0);
        m_abort = 1'b1;
        step();
        m_abort = 1'b0;
        m_mode  = M_NORMAL;
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        chk("busy_tmo_cleared", tmo_err, 0);

        // Trigger overrun: pulses at relative cycles 0, 5 and 8.
        base = m_conv;
        nf   = fall_cyc.size();
        m_data.push_back(5'd13);
        m_data.push_back(5'd27);
`ifndef SAR_HOST_AVG_EN
        sb.push_back(5'd13);
        sb.push_back(5'd27);
`endif
        trig = 1'b1;
        step();
        trig = 1'b0;
        repeat (4) step();
        trig = 1'b1;
        step();
        trig = 1'b0;
        chk("second_trig_not_overrun", trig_ovr, 0);
        repeat (2) step();
        trig = 1'b1;
        step();
        trig = 1'b0;
        wait_conv(base + 2);
        repeat (43) step();
        chk("overrun_request_count", fall_cyc.size() - nf, 2);
        chk("overrun_conversions", m_conv - base, 2);
        chk("trig_ovr_set", trig_ovr, 1);
`ifdef SAR_HOST_AVG_EN
        chk("overrun_avg_no_push", count, 0);
`else
        chk("overrun_count", count, 2);
        for (int k = 0; k < 2; k++) begin
            chk("overrun_pop", rd_data, sb.pop_front());
            rd_en = 1'b1;
            step();
            rd_en = 1'b0;
        end
        chk("overrun_empty", empty, 1);
`endif
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        chk("trig_ovr_cleared", trig_ovr, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
